// File: rtl/otter_cache_pkg.sv
// Shared definitions for the OTTER two-way data cache and its refill engine.
// Holds line geometry, address field widths, the refill FSM state type and
// small address helpers used by both the cache arrays and cache_line_fill.
package otter_cache_pkg;

    // Geometry of one cache line and of the memory bus word.
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 8;
    localparam int LINE_BITS  = LINE_WORDS * DATA_W;

    // Byte-address split: tag [31:8], index [7:5], word [4:2], byte [1:0].
    localparam int TAG_W      = 24;
    localparam int INDEX_W    = 3;
    localparam int WORD_W     = 3;
    localparam int BYTE_W     = 2;
    localparam int OFFSET_W   = WORD_W + BYTE_W;

    // Refill engine states; exported on the debug port of cache_line_fill.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    // Base byte address of the line containing addr (offset bits cleared).
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    // Byte address of word w inside the line starting at base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [WORD_W-1:0] w);
        return base + ADDR_W'({w, {BYTE_W{1'b0}}});
    endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Memory-side refill / write-back engine for the OTTER two-way data cache.
// Accepts one miss from the cache, optionally writes the dirty victim line
// back word by word, then reads the missing line word by word and hands the
// assembled 256-bit line back with a single-cycle fill_valid pulse.
//
// Handshakes:
//   Cache side : miss_req is sampled only while IDLE; the cycle it is seen
//                high the request and all victim_* inputs are captured, and
//                they are ignored until the engine returns to IDLE. fill_valid
//                is a one-cycle pulse; fill_addr/fill_data then hold until the
//                next FILL phase overwrites them.
//   Memory side: mem_rd or mem_we (never both) is a request held high together
//                with a stable mem_addr/mem_wdata until the cycle mem_ack=1
//                completes the beat; the next beat is presented the cycle
//                after. mem_ack is ignored when no request is outstanding.
module cache_line_fill
    import otter_cache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    // cache side
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_W-1:0]     victim_addr,
    input  logic [LINE_BITS-1:0]  victim_data,
    output logic                  fill_valid,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [LINE_BITS-1:0]  fill_data,
    output logic                  busy,
    // memory side
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    // debug visibility of the sequencer
    output fill_state_t           dbg_state,
    output logic [WORD_W-1:0]     dbg_cnt
);

    fill_state_t                         state_q, state_d;
    logic        [WORD_W-1:0]            cnt_q;
    logic        [ADDR_W-1:0]            miss_base_q;
    logic        [ADDR_W-1:0]            victim_base_q;
    logic        [LINE_WORDS-1:0][DATA_W-1:0] victim_words_q;
    logic        [LINE_WORDS-1:0][DATA_W-1:0] fill_words_q;
    logic        [ADDR_W-1:0]            fill_addr_q;

    logic accept;      // miss taken this cycle
    logic beat_done;   // outstanding memory beat completes this cycle
    logic last_beat;   // current beat is word LINE_WORDS-1

    assign accept    = (state_q == IDLE) && miss_req;
    assign beat_done = mem_ack && ((state_q == WB) || (state_q == FILL));
    assign last_beat = (cnt_q == {WORD_W{1'b1}});

    assign fill_addr = fill_addr_q;
    assign fill_data = fill_words_q;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // State register; reset aborts any transaction on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory/cache outputs, all decoded from the current state.
    always_comb begin
        state_d    = state_q;
        fill_valid = 1'b0;
        busy       = (state_q != IDLE);
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    state_d = victim_dirty ? WB : FILL;
                end
            end
            WB: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr(victim_base_q, cnt_q);
                mem_wdata = victim_words_q[cnt_q];
                if (mem_ack && last_beat) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = word_addr(miss_base_q, cnt_q);
                if (mem_ack && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                fill_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat counter: cleared on accept, advances on each acked beat and wraps
    // from 7 to 0 between the write-back and fill phases.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (beat_done) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Capture of the request; held stable for the whole transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_base_q    <= '0;
            victim_base_q  <= '0;
            victim_words_q <= '0;
        end else if (accept) begin
            miss_base_q    <= line_base(miss_addr);
            victim_base_q  <= line_base(victim_addr);
            victim_words_q <= victim_data;
        end
    end

    // Line assembly: each acked read beat lands in word cnt; the line base is
    // published with the final word so fill_addr always matches fill_data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_words_q <= '0;
            fill_addr_q  <= '0;
        end else if ((state_q == FILL) && mem_ack) begin
            fill_words_q[cnt_q] <= mem_rdata;
            if (last_beat) begin
                fill_addr_q <= miss_base_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: directed scenarios followed by
// randomized misses, checked against a transaction-level reference model
// (expected beat list, expected line and expected completion cycle).
module tb_cache_line_fill;
    import otter_cache_pkg::*;

    logic                 CLK;
    logic                 RST;
    logic                 miss_req;
    logic [31:0]          miss_addr;
    logic                 victim_dirty;
    logic [31:0]          victim_addr;
    logic [255:0]         victim_data;
    logic                 fill_valid;
    logic [31:0]          fill_addr;
    logic [255:0]         fill_data;
    logic                 busy;
    logic [31:0]          mem_addr;
    logic                 mem_rd;
    logic                 mem_we;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_ack;
    fill_state_t          dbg_state;
    logic [2:0]           dbg_cnt;

    int vectors;
    int miscompares;

    // Expected memory beats: {is_write, byte address, write data}.
    logic [64:0] exp_q[$];

    cache_line_fill dut (
        .CLK          (CLK),
        .RST          (RST),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .victim_data  (victim_data),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .dbg_state    (dbg_state),
        .dbg_cnt      (dbg_cnt)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    // Comparison point
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All outputs at their reset/idle values
    task automatic check_quiet(input string tag, input bit with_line);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " fill_valid"}, fill_valid, 0);
        chk({tag, " mem_rd"}, mem_rd, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " state"}, dbg_state, IDLE);
        if (with_line) begin
            chk({tag, " fill_addr"}, fill_addr, 0);
            chk({tag, " fill_data"}, fill_data, 0);
            chk({tag, " cnt"}, dbg_cnt, 0);
        end
    endtask

    // Spurious acks while idle must not start anything
    task automatic spurious_acks(input int n);
        miss_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            @(negedge CLK);
            check_quiet("spurious", 1'b0);
        end
        mem_ack = 1'b0;
    endtask

    // One miss transaction. Called at a negedge with the DUT idle; returns at
    // the negedge of the IDLE cycle that follows fill_valid (or after abort).
    // Memory word at byte address a reads as a ^ key.
    task automatic run_txn(input string name, input logic [31:0] maddr,
                           input logic dirty, input logic [31:0] vaddr,
                           input logic [255:0] vdata, input logic [31:0] key,
                           input int period, input bit disturb,
                           input bit hold_after, input int abort_read);
        logic [31:0]  mbase;
        logic [31:0]  vbase;
        logic [255:0] exp_line;
        logic [64:0]  f;
        int           exp_done;
        int           cyc;
        int           wait_cnt;
        int           reads_done;

        mbase = maddr & 32'hFFFF_FFE0;
        vbase = vaddr & 32'hFFFF_FFE0;
        exp_q.delete();
        if (dirty) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({1'b1, vbase + 32'(4 * k), vdata[32*k +: 32]});
            end
        end
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({1'b0, mbase + 32'(4 * k), 32'h0});
            exp_line[32*k +: 32] = (mbase + 32'(4 * k)) ^ key;
        end
        exp_done = 1 + exp_q.size() * period;

        chk({name, " idle before accept"}, busy, 0);
        miss_req     = 1'b1;
        miss_addr    = maddr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        victim_data  = vdata;
        mem_ack      = 1'b0;
        cyc          = 0;
        wait_cnt     = 0;
        reads_done   = 0;

        while (exp_q.size() != 0) begin
            @(negedge CLK);
            cyc++;
            mem_ack = 1'b0;
            if (disturb) begin
                miss_req     = 1'($urandom_range(0, 1));
                miss_addr    = $urandom;
                victim_dirty = 1'($urandom_range(0, 1));
                victim_addr  = $urandom;
                for (int k = 0; k < 8; k++) victim_data[32*k +: 32] = $urandom;
            end else begin
                miss_req = 1'b0;
            end
            f = exp_q[0];
            chk({name, " busy"}, busy, 1);
            chk({name, " fill_valid early"}, fill_valid, 0);
            chk({name, " mem_we"}, mem_we, f[64]);
            chk({name, " mem_rd"}, mem_rd, !f[64]);
            chk({name, " mem_addr"}, mem_addr, f[63:32]);
            if (f[64]) chk({name, " mem_wdata"}, mem_wdata, f[31:0]);
            if (!f[64] && reads_done == abort_read) begin
                RST      = 1'b1;
                miss_req = 1'b0;
                @(negedge CLK);
                check_quiet({name, " after reset"}, 1'b1);
                RST = 1'b0;
                exp_q.delete();
                return;
            end
            mem_rdata = mem_addr ^ key;
            if (wait_cnt == period - 1) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                void'(exp_q.pop_front());
                if (!f[64]) reads_done++;
            end else begin
                wait_cnt++;
            end
        end

        @(negedge CLK);
        cyc++;
        mem_ack  = 1'b0;
        miss_req = hold_after;
        chk({name, " fill_valid"}, fill_valid, 1);
        chk({name, " fill cycle"}, 256'(cyc), 256'(exp_done));
        chk({name, " fill_addr"}, fill_addr, mbase);
        chk({name, " fill_data"}, fill_data, exp_line);
        chk({name, " busy in done"}, busy, 1);
        chk({name, " no request in done"}, {mem_rd, mem_we}, 2'b00);

        @(negedge CLK);
        chk({name, " pulse width"}, fill_valid, 0);
        chk({name, " back to idle"}, dbg_state, IDLE);
        chk({name, " busy after"}, busy, 0);
        chk({name, " fill_data held"}, fill_data, exp_line);
        chk({name, " fill_addr held"}, fill_addr, mbase);
    endtask

    // Directed then randomized scenarios
    initial begin
        logic [255:0] vline;
        logic [31:0]  ma;
        logic [31:0]  va;
        logic [31:0]  key;

        vectors      = 0;
        miscompares  = 0;
        RST          = 1'b1;
        miss_req     = 1'b0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_addr  = '0;
        victim_data  = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;

        repeat (3) @(negedge CLK);
        check_quiet("reset", 1'b1);
        RST = 1'b0;
        @(negedge CLK);
        check_quiet("post reset", 1'b1);

        spurious_acks(3);

        run_txn("clean", 32'h0000_1234, 1'b0, 32'h0, '0, 32'hA5A5_0000, 1, 1'b0, 1'b0, -1);

        for (int k = 0; k < 8; k++) vline[32*k +: 32] = 32'h1000_0000 + 32'(k);
        run_txn("dirty", 32'h0000_1234, 1'b1, 32'h0000_0A40, vline, 32'hA5A5_0000, 1, 1'b0, 1'b0, -1);

        run_txn("waits", 32'h0000_1234, 1'b0, 32'h0, '0, 32'hA5A5_0000, 3, 1'b0, 1'b0, -1);

        run_txn("abort", 32'h0000_1234, 1'b0, 32'h0, '0, 32'hA5A5_0000, 1, 1'b0, 1'b0, 4);
        run_txn("after abort", 32'h0000_1234, 1'b0, 32'h0, '0, 32'h0F0F_F0F0, 1, 1'b0, 1'b0, -1);

        spurious_acks(2);

        for (int k = 0; k < 8; k++) vline[32*k +: 32] = $urandom;
        run_txn("disturb", $urandom, 1'b1, $urandom, vline, $urandom, 2, 1'b1, 1'b1, -1);
        run_txn("back to back", $urandom, 1'b0, $urandom, vline, $urandom, 1, 1'b0, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            ma  = $urandom;
            va  = $urandom;
            key = $urandom;
            for (int k = 0; k < 8; k++) vline[32*k +: 32] = $urandom;
            run_txn("random", ma, 1'($urandom_range(0, 1)), va, vline, key,
                    $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0, -1);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
